and_chain_collector: RTL and testbench



---
 rtl/and_chain_pkg.sv | 13 +
 rtl/and_chain_pair_shreg.sv | 42 ++++
 rtl/and_chain_collector.sv | 120 ++++++++++++
 tb/tb_and_chain_collector.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/and_chain_pkg.sv
// Shared types and constants for the AND-chain output collector.
package and_chain_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam int PAIR_W             = 2;
  localparam int DEFAULT_WORD_PAIRS = 4;
  localparam int ERRCNT_W           = 8;

endpackage

// File: rtl/and_chain_pair_shreg.sv
// Word register for the collector: writes each accepted pair into its slot
// and walks the pair index, wrapping after the last slot.
// load restarts a word: the pair goes to slot 0 and the index moves to 1.
module and_chain_pair_shreg
  import and_chain_pkg::*;
#(
  parameter  int WORD_PAIRS = DEFAULT_WORD_PAIRS,
  localparam int IDX_W      = $clog2(WORD_PAIRS)
) (
  input  logic                         clk_sys,
  input  logic                         rst_b,
  input  logic                         en,
  input  logic                         load,
  input  logic [PAIR_W-1:0]            pair,
  output logic [PAIR_W*WORD_PAIRS-1:0] word,
  output logic [IDX_W-1:0]             idx,
  output logic                         last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_PAIRS - 1);

  assign last = (idx == LAST_IDX);

  // Slot write and index advance on every accepted pair.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      word <= '0;
      idx  <= '0;
    end else if (en) begin
      if (load) begin
        word[PAIR_W-1:0] <= pair;
        idx              <= IDX_W'(1);
      end else begin
        for (int p = 0; p < WORD_PAIRS; p++) begin
          if (idx == IDX_W'(p)) word[PAIR_W*p +: PAIR_W] <= pair;
        end
        idx <= last ? '0 : idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/and_chain_collector.sv
// Collects 2-bit pairs from the AND-chain taps into words of WORD_PAIRS pairs,
// flagging any pair whose chain result differs from the pair MSB.
// Optional build macro: AND_CHAIN_COLLECTOR_ERRCNT_EN adds O_errcnt, a
// saturating count of every mismatched pair accepted since reset.
//
// state   | meaning
// COLLECT | accepting pairs of the current word, no word presented
// HOLD    | completed word presented; input accepted only as the word leaves
module and_chain_collector
  import and_chain_pkg::*;
#(
  parameter  int WORD_PAIRS = DEFAULT_WORD_PAIRS,
  localparam int IDX_W      = $clog2(WORD_PAIRS)
) (
  input  logic                         CLK,
  input  logic                         ASYNCRESETN,
  input  logic                         I_valid,
  input  logic [PAIR_W-1:0]            I,
  input  logic                         I_ref,
  output logic                         I_ready,
  output logic                         O_valid,
  output logic [PAIR_W*WORD_PAIRS-1:0] O,
  output logic                         O_err,
  input  logic                         O_ready
`ifdef AND_CHAIN_COLLECTOR_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]          O_errcnt
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic             in_xfer;
  logic             pair_err;
  logic             first_pair;
  logic             err_acc;
  logic             err_acc_nxt;
  logic             load;
  logic [IDX_W-1:0] idx;
  logic             last;

  assign in_xfer     = I_valid && I_ready;
  assign pair_err    = (I_ref != I[PAIR_W-1]);
  assign load        = (state == HOLD);
  // A pair taken in HOLD is always the first pair of the following word.
  assign first_pair  = load || (idx == '0);
  assign err_acc_nxt = first_pair ? pair_err : (err_acc | pair_err);

  and_chain_pair_shreg #(
    .WORD_PAIRS (WORD_PAIRS)
  ) u_shreg (
    .clk_sys (CLK),
    .rst_b   (ASYNCRESETN),
    .en      (in_xfer),
    .load    (load),
    .pair    (I),
    .word    (O),
    .idx     (idx),
    .last    (last)
  );

  // State register.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) state <= COLLECT;
    else              state <= state_nxt;
  end

  // Next state: finish a word into HOLD, release it on downstream ready.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (in_xfer && last) state_nxt = HOLD;
      HOLD:    if (O_ready)         state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    I_ready = 1'b1;
    O_valid = 1'b0;
    case (state)
      COLLECT: begin
        I_ready = 1'b1;
        O_valid = 1'b0;
      end
      HOLD: begin
        I_ready = O_ready;
        O_valid = 1'b1;
      end
      default: begin
        I_ready = 1'b1;
        O_valid = 1'b0;
      end
    endcase
  end

  // Per-word mismatch accumulation; the flag is frozen when the word completes.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      err_acc <= 1'b0;
      O_err   <= 1'b0;
    end else if (in_xfer) begin
      err_acc <= err_acc_nxt;
      if ((state == COLLECT) && last) O_err <= err_acc_nxt;
    end
  end

`ifdef AND_CHAIN_COLLECTOR_ERRCNT_EN
  // Lifetime count of mismatched pairs, sticking at all-ones.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      O_errcnt <= '0;
    end else if (in_xfer && pair_err && (O_errcnt != {ERRCNT_W{1'b1}})) begin
      O_errcnt <= O_errcnt + ERRCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_and_chain_collector.sv
// Directed and randomized bench for and_chain_collector against a queue-based
// reference model of pair collection, word completion and the handshake.
module tb_and_chain_collector;
  import and_chain_pkg::*;

  localparam int WP = 4;
  localparam int OW = 2 * WP;

  logic          CLK = 1'b0;
  logic          ASYNCRESETN = 1'b0;
  logic          I_valid = 1'b0;
  logic [1:0]    I = 2'b00;
  logic          I_ref = 1'b0;
  logic          O_ready = 1'b0;
  logic          I_ready;
  logic          O_valid;
  logic [OW-1:0] O;
  logic          O_err;
`ifdef AND_CHAIN_COLLECTOR_ERRCNT_EN
  logic [7:0]    O_errcnt;
`endif

  and_chain_collector #(.WORD_PAIRS(WP)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .I_valid     (I_valid),
    .I           (I),
    .I_ref       (I_ref),
    .I_ready     (I_ready),
    .O_valid     (O_valid),
    .O           (O),
    .O_err       (O_err),
    .O_ready     (O_ready)
`ifdef AND_CHAIN_COLLECTOR_ERRCNT_EN
    ,
    .O_errcnt    (O_errcnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [OW-1:0] w;
    logic          e;
  } word_t;

  int            n_total = 0;
  int            n_pass  = 0;
  word_t         exp_q[$];
  logic [1:0]    cur_q[$];
  logic          cur_err = 1'b0;
  int            model_cnt = 0;
  logic [OW-1:0] obs_word;
  logic          obs_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    exp_q.delete();
    cur_q.delete();
    cur_err   = 1'b0;
    model_cnt = 0;
  endtask

  // One clock of stimulus; outputs are checked mid-cycle against the model,
  // then the transfers of this cycle are applied to the model.
  task automatic step(input logic v, input logic [1:0] p, input logic r, input logic ordy);
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] w;
    word_t         nw;
    @(negedge CLK);
    I_valid = v;
    I       = p;
    I_ref   = r;
    O_ready = ordy;
    #1;
    m_valid = (exp_q.size() != 0);
    m_ready = !m_valid || ordy;
    check("o_valid", O_valid, m_valid);
    check("i_ready", I_ready, m_ready);
    if (m_valid) begin
      check("o_word", O, exp_q[0].w);
      check("o_err", O_err, exp_q[0].e);
    end
`ifdef AND_CHAIN_COLLECTOR_ERRCNT_EN
    check("o_errcnt", O_errcnt, model_cnt);
`endif
    if (m_valid && ordy) begin
      obs_word = O;
      obs_err  = O_err;
      exp_q.delete(0);
    end
    if (v && m_ready) begin
      cur_q.push_back(p);
      if (r != p[1]) begin
        cur_err = 1'b1;
        if (model_cnt < 255) model_cnt++;
      end
      if (cur_q.size() == WP) begin
        w = '0;
        for (int k = 0; k < WP; k++) w = w | (OW'(cur_q[k]) << (2 * k));
        nw.w = w;
        nw.e = cur_err;
        exp_q.push_back(nw);
        cur_q.delete();
        cur_err = 1'b0;
      end
    end
  endtask

  task automatic reset_mid_cycle();
    @(negedge CLK);
    I_valid = 1'b0;
    O_ready = 1'b0;
    #2 ASYNCRESETN = 1'b0;
    #1;
    check("rst_o_valid", O_valid, 1'b0);
    check("rst_o", O, '0);
    check("rst_i_ready", I_ready, 1'b1);
    check("rst_o_err", O_err, 1'b0);
`ifdef AND_CHAIN_COLLECTOR_ERRCNT_EN
    check("rst_errcnt", O_errcnt, 0);
`endif
    model_clear();
    @(negedge CLK);
    #2 ASYNCRESETN = 1'b1;
  endtask

  initial begin
    // Power-on reset
    #3;
    check("por_o_valid", O_valid, 1'b0);
    check("por_o", O, '0);
    check("por_i_ready", I_ready, 1'b1);
    check("por_o_err", O_err, 1'b0);
    @(negedge CLK);
    #2 ASYNCRESETN = 1'b1;

    // Basic word, back-to-back with O_ready high
    obs_word = '0; obs_err = 1'bx;
    step(1, 2'b10, 1, 1);
    step(1, 2'b11, 1, 1);
    step(1, 2'b00, 0, 1);
    step(1, 2'b01, 0, 1);
    check("basic_valid_lat", O_valid, 1'b0);
    step(0, 2'b00, 0, 1);
    step(0, 2'b00, 0, 1);
    check("basic_word", obs_word, 8'h4E);
    check("basic_err", obs_err, 1'b0);

    // Mismatch on the third pair, then a clean word
    obs_word = '0; obs_err = 1'bx;
    step(1, 2'b10, 1, 1);
    step(1, 2'b11, 1, 1);
    step(1, 2'b00, 1, 1);
    step(1, 2'b01, 0, 1);
    step(0, 2'b00, 0, 1);
    check("mis_word", obs_word, 8'h4E);
    check("mis_err", obs_err, 1'b1);
`ifdef AND_CHAIN_COLLECTOR_ERRCNT_EN
    step(0, 2'b00, 0, 1);
    check("mis_errcnt", O_errcnt, 1);
`endif
    obs_err = 1'bx;
    step(1, 2'b10, 1, 1);
    step(1, 2'b11, 1, 1);
    step(1, 2'b00, 0, 1);
    step(1, 2'b01, 0, 1);
    step(0, 2'b00, 0, 1);
    check("clean_err", obs_err, 1'b0);

    // Backpressure: word held for 5 cycles with input offered
    step(1, 2'b01, 0, 0);
    step(1, 2'b10, 1, 0);
    step(1, 2'b11, 1, 0);
    step(1, 2'b00, 0, 0);
    for (int c = 0; c < 5; c++) step(1, 2'b11, 0, 0);
    obs_word = '0;
    step(0, 2'b00, 0, 1);
    check("bp_word", obs_word, 8'h39);
    step(0, 2'b00, 0, 1);
    check("bp_after", O_valid, 1'b0);

    // Simultaneous word exit and next-word first pair
    step(1, 2'b01, 0, 0);
    step(1, 2'b01, 0, 0);
    step(1, 2'b01, 0, 0);
    step(1, 2'b01, 0, 0);
    step(1, 2'b11, 1, 1);
    check("sim_prev_word", obs_word, 8'h55);
    obs_word = '0; obs_err = 1'bx;
    step(1, 2'b00, 0, 1);
    step(1, 2'b00, 0, 1);
    step(1, 2'b00, 0, 1);
    step(0, 2'b00, 0, 1);
    check("sim_word", obs_word, 8'h03);
    check("sim_err", obs_err, 1'b0);

    // Reset mid-word discards the partial word
    step(1, 2'b11, 0, 1);
    step(1, 2'b11, 0, 1);
    reset_mid_cycle();
    obs_word = '0;
    step(1, 2'b01, 0, 1);
    step(1, 2'b10, 1, 1);
    step(1, 2'b01, 0, 1);
    step(1, 2'b10, 1, 1);
    step(0, 2'b00, 0, 1);
    check("post_rst_word", obs_word, 8'h99);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 3; n++) step(0, 2'b00, 0, 1);

`ifdef AND_CHAIN_COLLECTOR_ERRCNT_EN
    // Saturation of the mismatch counter
    reset_mid_cycle();
    for (int n = 0; n < 300; n++) step(1, 2'b01, 1, 1);
    step(0, 2'b00, 0, 1);
    step(0, 2'b00, 0, 1);
    check("errcnt_sat", O_errcnt, 8'hFF);
    step(1, 2'b00, 1, 1);
    step(0, 2'b00, 0, 1);
    check("errcnt_hold", O_errcnt, 8'hFF);
    reset_mid_cycle();
    step(0, 2'b00, 0, 1);
    check("errcnt_clear", O_errcnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
